// File: rtl/pb_event_pkg.sv
// Shared definitions for the push-button event decoder: event codes and
// the classification FSM state encoding.
package pb_event_pkg;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_SHORT  = 3'd1;
  localparam logic [2:0] EV_DOUBLE = 3'd2;
  localparam logic [2:0] EV_LONG   = 3'd3;
  localparam logic [2:0] EV_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DOWN1   = 3'd1,
    ST_UP_WAIT = 3'd2,
    ST_DOWN2   = 3'd3,
    ST_HELD    = 3'd4
  } pb_state_t;

endpackage

// File: rtl/pb_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV cycles.
// The tick is high while the divider sits on its terminal count.
module pb_tick_gen #(
  parameter int TICK_DIV = 24000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/pb_event_decoder.sv
// Push-button event decoder: classifies debounced presses into SHORT,
// DOUBLE, LONG and optional REPEAT events timed on a 1 ms tick, and hands
// them to the consumer through a one-deep valid/ready holding register.
// Optional feature macro: AUTO_REPEAT_EN (REPEAT events while held).
module pb_event_decoder #(
  parameter int TICK_DIV   = 24000,
  parameter int LONG_MS    = 800,
  parameter int DCLICK_MS  = 300,
  parameter int REPEAT_MS  = 150,
  parameter int ACTIVE_LOW = 1,
  parameter int MS_BITS    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clean_pb,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [2:0] event_code,
  output logic       pressed,
  output logic       overflow,
  input  logic       overflow_clr
);

  import pb_event_pkg::*;

  localparam logic [MS_BITS-1:0] LONG_T   = MS_BITS'(LONG_MS);
  localparam logic [MS_BITS-1:0] DCLICK_T = MS_BITS'(DCLICK_MS);
  localparam logic [MS_BITS-1:0] REPEAT_T = MS_BITS'(REPEAT_MS);

  logic               tick;
  logic               pb_lvl;
  logic               vld_p0;
  logic               armed;
  pb_state_t          state;
  pb_state_t          state_nxt;
  logic [MS_BITS-1:0] ms_cnt;
  logic               ms_restart;
  logic               emit;
  logic [2:0]         emit_code;

  pb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign pb_lvl = (ACTIVE_LOW != 0) ? ~clean_pb : clean_pb;

  // Stage p0: polarity-corrected button level. vld_p0 marks that pressed
  // holds a real sample rather than its reset value, so arming never keys
  // off the reset value of a button held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      pressed <= pb_lvl;
      vld_p0  <= 1'b1;
    end
  end

  // Arm only after a genuine released sample has been observed.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (vld_p0 && !pressed) begin
      armed <= 1'b1;
    end
  end

  // Classification decision: next state, event to emit, counter restart.
  // Release is tested before timeout so that it wins a same-cycle tie.
  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    emit_code  = EV_NONE;
    ms_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pressed && armed) state_nxt = ST_DOWN1;
      end
      ST_DOWN1: begin
        if (!pressed) begin
          state_nxt = ST_UP_WAIT;
        end else if (ms_cnt == LONG_T) begin
          emit      = 1'b1;
          emit_code = EV_LONG;
          state_nxt = ST_HELD;
        end
      end
      ST_UP_WAIT: begin
        if (pressed) begin
          state_nxt = ST_DOWN2;
        end else if (ms_cnt == DCLICK_T) begin
          emit      = 1'b1;
          emit_code = EV_SHORT;
          state_nxt = ST_IDLE;
        end
      end
      ST_DOWN2: begin
        if (!pressed) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
          state_nxt = ST_IDLE;
        end else if (ms_cnt == LONG_T) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        // The counter restarts every REPEAT_MS while held either way, which
        // also keeps it bounded during very long holds.
        if (!pressed) begin
          state_nxt = ST_IDLE;
        end else if (ms_cnt == REPEAT_T) begin
          ms_restart = 1'b1;
`ifdef AUTO_REPEAT_EN
          emit       = 1'b1;
          emit_code  = EV_REPEAT;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and ms counter; the counter clears on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ms_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || ms_restart) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_cnt + MS_BITS'(1);
      end
    end
  end

  // Stage p1: one-deep holding register with sticky overflow on a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_code  <= EV_NONE;
      overflow    <= 1'b0;
    end else begin
      if (emit && (!event_valid || event_ready)) begin
        event_valid <= 1'b1;
        event_code  <= emit_code;
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
        event_code  <= EV_NONE;
      end
      if (emit && event_valid && !event_ready) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Scoreboard bench for pb_event_decoder. Gestures are issued with clock
// counts chosen well clear of the +-1 ms timing window; the expected event
// sequence of each gesture is queued when it is issued and a monitor pops
// and compares on every accepted event.
module tb_pb_event_decoder;

  localparam int TICK_DIV  = 4;
  localparam int LONG_MS   = 10;
  localparam int DCLICK_MS = 5;
  localparam int REPEAT_MS = 3;

  localparam logic [2:0] C_SHORT  = 3'd1;
  localparam logic [2:0] C_DOUBLE = 3'd2;
  localparam logic [2:0] C_LONG   = 3'd3;
  localparam logic [2:0] C_REPEAT = 3'd4;

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       clean_pb     = 1'b1;
  logic       event_ready  = 1'b1;
  logic       overflow_clr = 1'b0;
  logic       event_valid;
  logic       pressed;
  logic       overflow;
  logic [2:0] event_code;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic       exp_pressed = 1'b0;

  always #5 clk = ~clk;

  pb_event_decoder #(
    .TICK_DIV   (TICK_DIV),
    .LONG_MS    (LONG_MS),
    .DCLICK_MS  (DCLICK_MS),
    .REPEAT_MS  (REPEAT_MS),
    .ACTIVE_LOW (1),
    .MS_BITS    (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clean_pb     (clean_pb),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_code   (event_code),
    .pressed      (pressed),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // pressed is the active-low input delayed by one clock, zero under reset.
  always @(posedge clk) exp_pressed <= reset ? 1'b0 : !clean_pb;

  // Monitor: compare every accepted event against the scoreboard queue.
  always @(negedge clk) begin
    check("pressed", pressed, exp_pressed);
    if (event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d, expected no event", event_code);
      end else begin
        check("event_code", event_code, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input int p);
    clean_pb = 1'b0;
    cyc(p);
    clean_pb = 1'b1;
  endtask

  // A hold of 46+12k clocks on a single press yields LONG and k REPEATs.
  task automatic push_held(input logic [2:0] first, input int k);
    exp_q.push_back(first);
    if (REP_EN) begin
      for (int i = 0; i < k; i++) exp_q.push_back(C_REPEAT);
    end
  endtask

  task automatic gesture(input int kind);
    int p1, p2, g, k;
    p1 = $urandom_range(8, 30);
    p2 = $urandom_range(8, 30);
    g  = $urandom_range(2, 12);
    k  = $urandom_range(0, 3);
    case (kind)
      0: begin
        exp_q.push_back(C_SHORT);
        hold(p1);
      end
      1: begin
        exp_q.push_back(C_DOUBLE);
        hold(p1);
        cyc(g);
        hold(p2);
      end
      2: begin
        push_held(C_LONG, k);
        hold(46 + 12 * k);
      end
      default: begin
        push_held(C_DOUBLE, k);
        hold(p1);
        cyc(g);
        hold(46 + 12 * k);
      end
    endcase
    cyc($urandom_range(30, 50));
  endtask

  initial begin
    reset = 1'b1;
    cyc(3);
    check("rst_valid", event_valid, 0);
    check("rst_code", event_code, 0);
    check("rst_pressed", pressed, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    cyc(5);

    // Single 3 ms click.
    exp_q.push_back(C_SHORT);
    hold(12);
    cyc(40);

    // Double click: event two clocks after the second release.
    exp_q.push_back(C_DOUBLE);
    hold(12);
    cyc(8);
    hold(12);
    @(posedge clk); #1;
    check("dbl_lat1_valid", event_valid, 0);
    @(posedge clk); #1;
    check("dbl_lat2_valid", event_valid, 1);
    check("dbl_lat2_code", event_code, C_DOUBLE);
    cyc(40);

    // Hold 20 ms: LONG at ~10 ms, REPEATs at ~13/16/19 ms when enabled.
    push_held(C_LONG, 3);
    hold(80);
    cyc(40);

    // Randomized gesture mix.
    for (int i = 0; i < 30; i++) gesture($urandom_range(0, 3));

    // Back-pressure: second SHORT dropped, first held stable.
    event_ready = 1'b0;
    exp_q.push_back(C_SHORT);
    hold(12);
    cyc(40);
    check("ovf_first_valid", event_valid, 1);
    check("ovf_first_code", event_code, C_SHORT);
    check("ovf_first_flag", overflow, 0);
    hold(12);
    cyc(40);
    check("ovf_hold_valid", event_valid, 1);
    check("ovf_hold_code", event_code, C_SHORT);
    check("ovf_set_flag", overflow, 1);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("ovf_clr_flag", overflow, 0);
    check("ovf_clr_valid", event_valid, 1);
    event_ready = 1'b1;
    cyc(1);
    check("ovf_drain_valid", event_valid, 0);
    check("ovf_drain_code", event_code, 0);
    cyc(10);

    // Button held through reset: no events until released and pressed again.
    clean_pb = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(80);
    check("held_rst_valid", event_valid, 0);
    check("held_rst_pressed", pressed, 1);
    clean_pb = 1'b1;
    cyc(10);
    exp_q.push_back(C_SHORT);
    hold(12);
    cyc(40);

    // Reset pulse while in DOWN1: outputs clear, that press is discarded.
    clean_pb = 1'b0;
    cyc(8);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("down1_rst_valid", event_valid, 0);
    check("down1_rst_code", event_code, 0);
    check("down1_rst_pressed", pressed, 0);
    check("down1_rst_overflow", overflow, 0);
    cyc(80);
    clean_pb = 1'b1;
    cyc(40);
    check("down1_rst_noevent", event_valid, 0);

    // Decoder recovers normally afterwards.
    exp_q.push_back(C_SHORT);
    hold(12);
    cyc(40);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
